// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared classes, stage types, flag indices and helpers for fp_mul_pipe
package fp_mul_pkg;
    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;
    // Control that travels alongside the datapath of every stage
    typedef struct packed {
        logic      valid;
        logic      sign;
        fp_class_e ca;
        fp_class_e cb;
    } stage_ctl_t;
    // Rounding information handed from normalisation to the rounding stage
    typedef struct packed {
        logic g;
        logic r;
        logic s;
        logic tiny;
    } rnd_bits_t;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;
    function automatic int bias(input int exp_len);
        return (1 << (exp_len - 1)) - 1;
    endfunction
    function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic mant_zero, input logic mant_msb);
        return exp_zero ? (mant_zero ? ZERO : SUB)
             : exp_ones ? (mant_zero ? INF : mant_msb ? QNAN : SNAN)
             : NORM;
    endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter, returns W for an all-zero input
// Ports: i_data (W bits) in, o_count ($clog2(W+1) bits) out
module fp_lzc #(
    parameter int W = 22,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_count
);
    // Ascending scan: the highest set bit is the last one to write the count
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < W; i++)
            if (i_data[i]) o_count = CW'(W - 1 - i);
    end
endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier (unpack/multiply, normalise, round)
// Ports: clk, rst (sync active-high); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/result/flags result handshake, flags = {invalid, overflow, underflow, inexact}
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_LEN  = 5,
    parameter int MANT_LEN = 10,
    localparam int FLOAT_LEN = 1 + EXP_LEN + MANT_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOAT_LEN-1:0] a,
    input  logic [FLOAT_LEN-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLOAT_LEN-1:0] result,
    output logic [3:0]           flags
);
    localparam int P    = MANT_LEN + 1;
    localparam int PW   = 2 * P;
    localparam int XW   = EXP_LEN + 2;
    localparam int LZW  = $clog2(PW + 1);
    localparam int BIAS = bias(EXP_LEN);
    localparam logic [EXP_LEN-1:0]  EXP_ONES  = '1;
    localparam logic [MANT_LEN-1:0] QNAN_MANT = {1'b1, {(MANT_LEN - 1){1'b0}}};

    logic w_en1, w_en2, w_en3;
    stage_ctl_t w1_ctl, r1_ctl, r2_ctl;
    logic [PW-1:0] r1_prod;
    logic [EXP_LEN:0] r1_esum, r2_exp;
    logic [MANT_LEN-1:0] r2_mant;
    rnd_bits_t r2_rnd;
    logic r_out_valid;
    logic [FLOAT_LEN-1:0] r_result;
    logic [3:0] r_flags;

    // Bubbles collapse: an empty stage always loads, a full one only when its successor moves
    assign w_en3    = ~r_out_valid | out_ready;
    assign w_en2    = ~r2_ctl.valid | w_en3;
    assign w_en1    = ~r1_ctl.valid | w_en2;
    assign in_ready = w_en3;

    // S1: unpack, classify, sign, significand product
    logic [EXP_LEN-1:0] w_ea, w_eb;
    logic [MANT_LEN-1:0] w_ma, w_mb;
    logic w_za, w_zb;
    assign w_ea = a[FLOAT_LEN-2:MANT_LEN];
    assign w_eb = b[FLOAT_LEN-2:MANT_LEN];
    assign w_ma = a[MANT_LEN-1:0];
    assign w_mb = b[MANT_LEN-1:0];
    assign w_za = ~|w_ea;
    assign w_zb = ~|w_eb;
    assign w1_ctl = '{valid: in_valid & in_ready,
                      sign:  a[FLOAT_LEN-1] ^ b[FLOAT_LEN-1],
                      ca:    classify(w_za, &w_ea, ~|w_ma, w_ma[MANT_LEN-1]),
                      cb:    classify(w_zb, &w_eb, ~|w_mb, w_mb[MANT_LEN-1])};

    // S2: normalise, unbounded biased exponent, denormalising shift with sticky
    logic [LZW-1:0] w_lz;
    logic [PW-1:0] w_norm;
    logic [PW-2:0] w_den;
    logic [XW-1:0] w_exp, w_sh_raw, w_sh;
    logic w_tiny, w_lost;
    fp_lzc #(.W(PW)) u_lzc (.i_data(r1_prod), .o_count(w_lz));
    assign w_norm   = r1_prod << w_lz;
    assign w_exp    = XW'(r1_esum) - XW'(BIAS) - XW'(w_lz) + XW'(1);
    assign w_tiny   = w_exp[XW-1] | ~|w_exp;
    assign w_sh_raw = XW'(1) - w_exp;
    // Shifts past MANT_LEN+2 all leave only sticky, so clamping there keeps the result exact
    assign w_sh     = !w_tiny ? '0 : w_sh_raw > XW'(MANT_LEN + 3) ? XW'(MANT_LEN + 3) : w_sh_raw;
    // The hidden bit is implied by the exponent field, so it is dropped here
    assign w_den    = (PW - 1)'(w_norm >> w_sh);
    assign w_lost   = |(w_norm & ~({PW{1'b1}} << w_sh));

    // S3: RNE on {exp, mant} so mantissa carry ripples into the exponent; then specials
    logic w_rnd, w_inx, w_ovf, w_inf_zero, w_nan, w_any_inf, w_any_zero, w_special;
    logic [EXP_LEN+MANT_LEN:0] w_sum;
    logic [FLOAT_LEN-1:0] w_res;
    logic [3:0] w_flg;
    assign w_rnd      = r2_rnd.g & (r2_rnd.r | r2_rnd.s | r2_mant[0]);
    assign w_inx      = r2_rnd.g | r2_rnd.r | r2_rnd.s;
    assign w_sum      = {r2_exp, r2_mant} + (EXP_LEN + MANT_LEN + 1)'(w_rnd);
    assign w_ovf      = w_sum[EXP_LEN+MANT_LEN:MANT_LEN] >= (EXP_LEN + 1)'((1 << EXP_LEN) - 1);
    assign w_inf_zero = (r2_ctl.ca == INF && r2_ctl.cb == ZERO) || (r2_ctl.ca == ZERO && r2_ctl.cb == INF);
    assign w_nan      = r2_ctl.ca inside {QNAN, SNAN} || r2_ctl.cb inside {QNAN, SNAN} || w_inf_zero;
    assign w_any_inf  = r2_ctl.ca == INF || r2_ctl.cb == INF;
    assign w_any_zero = r2_ctl.ca == ZERO || r2_ctl.cb == ZERO;
    assign w_special  = w_nan | w_any_inf | w_any_zero;
    assign w_res = w_nan                  ? {1'b0, EXP_ONES, QNAN_MANT}
                 : w_any_inf              ? {r2_ctl.sign, EXP_ONES, {MANT_LEN{1'b0}}}
                 : w_any_zero             ? {r2_ctl.sign, {(EXP_LEN + MANT_LEN){1'b0}}}
                 : w_ovf                  ? {r2_ctl.sign, EXP_ONES, {MANT_LEN{1'b0}}}
                 : {r2_ctl.sign, w_sum[EXP_LEN+MANT_LEN-1:0]};
    always_comb begin
        w_flg = '0;
        w_flg[FLAG_INVALID]   = w_inf_zero | r2_ctl.ca == SNAN | r2_ctl.cb == SNAN;
        w_flg[FLAG_OVERFLOW]  = ~w_special & w_ovf;
        w_flg[FLAG_UNDERFLOW] = ~w_special & r2_rnd.tiny & w_inx;
        w_flg[FLAG_INEXACT]   = ~w_special & (w_inx | w_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_ctl      <= '0;
            r2_ctl      <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else begin
            if (w_en1) begin
                r1_ctl  <= w1_ctl;
                r1_prod <= PW'({~w_za, w_ma}) * PW'({~w_zb, w_mb});
                // Subnormals use effective exponent 1
                r1_esum <= {1'b0, w_ea[EXP_LEN-1:1], w_ea[0] | w_za}
                         + {1'b0, w_eb[EXP_LEN-1:1], w_eb[0] | w_zb};
            end
            if (w_en2) begin
                r2_ctl  <= r1_ctl;
                r2_exp  <= w_tiny ? '0 : w_exp[EXP_LEN:0];
                r2_mant <= w_den[PW-2 -: MANT_LEN];
                r2_rnd  <= '{g: w_den[PW-P-1], r: w_den[PW-P-2],
                             s: |w_den[PW-P-3:0] | w_lost, tiny: w_tiny};
            end
            if (w_en3) begin
                r_out_valid <= r2_ctl.valid;
                r_result    <= w_res;
                r_flags     <= w_flg;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter EXP_LEN, default 5, SHALL set the exponent field width.
REQ-002 Parameter MANT_LEN, default 10, SHALL set the stored mantissa field width.
REQ-003 Derived constant FLOAT_LEN SHALL equal 1+EXP_LEN+MANT_LEN and SHALL NOT be overridable.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: operand pair a/b valid.
REQ-007 Port in_ready, output, 1: block accepts the operand pair this cycle.
REQ-008 Ports a and b, input, FLOAT_LEN each: IEEE-754-style operands (sign, biased exponent, mantissa).
REQ-009 Port out_valid, output, 1: result valid.
REQ-010 Port out_ready, input, 1: consumer accepts the result.
REQ-011 Port result, output, FLOAT_LEN: product.
REQ-012 Port flags, output, 4: {invalid, overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-013 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-014 Pipeline: 3 stages; S1 unpack, classify, sign XOR, full (MANT_LEN+1)x(MANT_LEN+1) product; S2 leading-zero normalise, signed exponent (EXP_LEN+2 bits) = ea+eb-bias-lz+1, denormalising right shift with sticky collection; S3 RNE round, overflow/underflow, special-case mux.
REQ-015 Latency SHALL be exactly 3 cycles from input transfer to out_valid when out_ready is held 1; throughput SHALL be 1 result per cycle.
REQ-016 Stall: when out_valid=1 and out_ready=0, all stages SHALL hold, in_ready SHALL be 0, and result/flags SHALL remain stable.
REQ-017 in_ready SHALL be 1 whenever the pipeline is not stalled; bubbles SHALL collapse (a stage with valid=0 is overwritten regardless of downstream stall).
REQ-018 Subnormal inputs (exp=0) SHALL use effective exponent 1 and hidden bit 0, with normalisation applied in S2.
REQ-019 Rounding SHALL be round-to-nearest-even using guard, round, sticky; mantissa carry-out SHALL increment the exponent.
REQ-020 Results whose exponent falls below 1 SHALL be produced as correctly rounded subnormals (gradual underflow); a shift beyond MANT_LEN+2 SHALL yield zero plus inexact.
REQ-021 Rounded exponent of all-ones or greater SHALL give signed infinity and set overflow and inexact.
REQ-022 underflow SHALL be set when the pre-rounding result is tiny and inexact is set.
REQ-023 inexact SHALL be set when any discarded bit (guard, round, or sticky) is nonzero.
REQ-024 NaN operand, or inf times zero, SHALL give canonical NaN (sign 0, exponent all-ones, mantissa MSB only); invalid SHALL be set only for inf times zero or a signalling NaN (mantissa MSB 0).
REQ-025 Inf times finite nonzero SHALL give signed infinity; zero times finite SHALL give signed zero; in both cases flags SHALL be 0.

Reset
REQ-026 On rst=1 all stage valid bits, out_valid, result and flags SHALL clear to 0 on the next edge; in_ready SHALL be 1 on the cycle after reset deasserts.
REQ-027 Reset mid-operation SHALL discard all in-flight operands, and no result from them SHALL appear afterwards.

Structure
REQ-028 Package fp_mul_pkg SHALL hold the bias function, the fp class enum (ZERO, SUB, NORM, INF, QNAN, SNAN), stage struct typedefs, and the flag bit indices.
REQ-029 Leading-zero count SHALL be a sub-module fp_lzc, parametrised by width.

Verification
REQ-030 1.0*1.0: a=3C00, b=3C00 -> result 3C00, flags 0, out_valid exactly 3 cycles after the transfer.
REQ-031 Overflow: 7BFF*4000 -> 7C00, overflow=1, inexact=1.
REQ-032 Rounding/underflow: 3C01*3C01 -> 3C02, inexact only; 0001*3800 -> 0000 (tie to even), underflow=1, inexact=1.
REQ-033 Specials: 7C00*0000 -> 7E00, invalid=1; 7D00*3C00 -> 7E00, invalid=1; FC00*3C00 -> FC00, flags 0.
REQ-034 Backpressure: stream 8 back-to-back pairs with out_ready toggling randomly -> results in order with none lost or duplicated, and outputs stable while stalled.
REQ-035 Reset with 3 operations in flight -> out_valid=0 next cycle, and no stale result afterwards.
